// File: rtl/rx_sample_ctrl.sv
// UART receive sequencer: oversampled start/data/parity/stop sampling with even-parity and framing checks.
// Optional build macro RX_MAJORITY_VOTE_EN enables 3-sample majority voting around the bit centre.
module rx_sample_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic rx_clk,
    input  logic reset,
    input  logic baud_tick,
    input  logic rx_in,
    input  logic rx_en,
    output logic start_bit_detected,
    output logic shift,
    output logic bit_value,
    output logic parity_load,
    output logic check_stop,
    output logic frame_done,
    output logic parity_error,
    output logic frame_error,
    output logic busy
);

    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [OS_W-1:0] OS_ZERO  = {OS_W{1'b0}};
    localparam logic [OS_W-1:0] OS_ONE   = OS_W'(1);
    localparam logic [OS_W-1:0] OS_SP    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_ZERO  = {BC_W{1'b0}};
    localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [OS_W-1:0] OS_DEC = OS_SP + OS_ONE;
`else
    localparam logic [OS_W-1:0] OS_DEC = OS_SP;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic            par_acc_q, par_acc_d;
    logic            parity_error_q, parity_error_d;

    logic            tick_s;
    logic            dec_s;
    logic            wrap_s;
    logic            sample_s;
    logic [OS_W-1:0] os_next_s;
    logic            start_s;
    logic            shift_s;
    logic            parity_load_s;
    logic            check_stop_s;
    logic            frame_err_s;

    // A tick only counts while enabled and out of reset, so reset and rx_en both silence every pulse.
    assign tick_s = baud_tick & rx_en & ~reset;
    assign dec_s  = tick_s & (os_cnt_q == OS_DEC);
    assign wrap_s = tick_s & (os_cnt_q == OS_LAST);

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] vote_q;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Capture the two samples that precede the decision tick.
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            vote_q <= 2'b00;
        end else if (tick_s && (os_cnt_q == (OS_SP - OS_ONE))) begin
            vote_q <= {vote_q[1], rx_in};
        end else if (tick_s && (os_cnt_q == OS_SP)) begin
            vote_q <= {rx_in, vote_q[0]};
        end else begin
            vote_q <= vote_q;
        end
    end

    assign sample_s = majority3(vote_q[0], vote_q[1], rx_in);
`else
    assign sample_s = rx_in;
`endif

    // Free-running sub-bit counter step, wrapping at the end of each bit period.
    always_comb begin
        os_next_s = os_cnt_q;
        if (tick_s) begin
            if (os_cnt_q == OS_LAST) begin
                os_next_s = OS_ZERO;
            end else begin
                os_next_s = os_cnt_q + OS_ONE;
            end
        end else begin
            os_next_s = os_cnt_q;
        end
    end

    // Next-state, counter and pulse decode.
    always_comb begin
        state_d        = state_q;
        os_cnt_d       = os_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        par_acc_d      = par_acc_q;
        parity_error_d = parity_error_q;
        start_s        = 1'b0;
        shift_s        = 1'b0;
        parity_load_s  = 1'b0;
        check_stop_s   = 1'b0;
        frame_err_s    = 1'b0;

        if (!rx_en && (state_q != ST_IDLE)) begin
            // Abort: drop the frame silently, keep the last parity verdict.
            state_d   = ST_IDLE;
            os_cnt_d  = OS_ZERO;
            bit_cnt_d = BC_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    os_cnt_d  = OS_ZERO;
                    bit_cnt_d = BC_ZERO;
                    if (rx_en && baud_tick && !rx_in) begin
                        state_d   = ST_START;
                        par_acc_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (dec_s && sample_s) begin
                        state_d  = ST_IDLE;
                        os_cnt_d = OS_ZERO;
                    end else begin
                        start_s  = dec_s;
                        os_cnt_d = os_next_s;
                        if (wrap_s) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = BC_ZERO;
                        end else begin
                            state_d = ST_START;
                        end
                    end
                end
                ST_DATA: begin
                    os_cnt_d = os_next_s;
                    if (dec_s) begin
                        shift_s   = 1'b1;
                        par_acc_d = par_acc_q ^ sample_s;
                    end else begin
                        shift_s = 1'b0;
                    end
                    if (wrap_s && (bit_cnt_q == BIT_LAST)) begin
                        state_d = ST_PARITY;
                    end else if (wrap_s) begin
                        bit_cnt_d = bit_cnt_q + BC_ONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    os_cnt_d = os_next_s;
                    if (dec_s) begin
                        parity_load_s  = 1'b1;
                        parity_error_d = par_acc_q ^ sample_s;
                    end else begin
                        parity_load_s = 1'b0;
                    end
                    if (wrap_s) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    // Return to idle at mid stop bit so the next start edge is caught early.
                    if (dec_s) begin
                        check_stop_s = 1'b1;
                        frame_err_s  = ~sample_s | parity_error_q;
                        state_d      = ST_IDLE;
                        os_cnt_d     = OS_ZERO;
                    end else begin
                        os_cnt_d = os_next_s;
                        state_d  = ST_STOP;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    os_cnt_d  = OS_ZERO;
                    bit_cnt_d = BC_ZERO;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            os_cnt_q       <= OS_ZERO;
            bit_cnt_q      <= BC_ZERO;
            par_acc_q      <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            os_cnt_q       <= os_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            par_acc_q      <= par_acc_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign start_bit_detected = start_s;
    assign shift              = shift_s;
    assign parity_load        = parity_load_s;
    assign check_stop         = check_stop_s;
    assign frame_done         = check_stop_s;
    assign frame_error        = frame_err_s;
    assign bit_value          = sample_s & (shift_s | parity_load_s | check_stop_s);
    assign parity_error       = parity_error_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_sample_ctrl.sv
// Self-checking bench for rx_sample_ctrl: directed frame table, corner sequences and random frames
// checked tick by tick against a line-level model of the receiver rules.
module tb_rx_sample_ctrl;

    localparam int DW  = 8;
    localparam int OS  = 16;
    localparam int LEN = (DW + 3) * OS;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int DEC = OS / 2;
    localparam bit MAJ = 1'b1;
`else
    localparam int DEC = OS / 2 - 1;
    localparam bit MAJ = 1'b0;
`endif

    logic rx_clk = 1'b0;
    logic reset, baud_tick, rx_in, rx_en;
    logic start_bit_detected, shift, bit_value, parity_load, check_stop;
    logic frame_done, parity_error, frame_error, busy;

    rx_sample_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .rx_clk(rx_clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_in), .rx_en(rx_en),
        .start_bit_detected(start_bit_detected), .shift(shift), .bit_value(bit_value),
        .parity_load(parity_load), .check_stop(check_stop), .frame_done(frame_done),
        .parity_error(parity_error), .frame_error(frame_error), .busy(busy)
    );

    always #5 rx_clk = ~rx_clk;

    // ev: 0 none, 1 start, 2 data, 3 parity, 4 stop; busy is the expected level before this tick's edge
    typedef struct packed {
        logic       lvl;
        logic [2:0] ev;
        logic       val;
        logic       busy;
    } tick_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          pbit;
        logic          sbit;
        logic          exp_pe;
        logic          exp_fe;
    } vec_t;

    tick_t   tq[$];
    vec_t    vecs[6];
    int      checks = 0;
    int      errors = 0;
    logic    pe_cur = 1'b0;
    logic    acc    = 1'b0;
    int      obs_cnt, obs_start, obs_fd;
    logic [DW-1:0] obs_bits;
    logic    obs_fe;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic clear_obs();
        obs_cnt = 0; obs_start = 0; obs_fd = 0; obs_bits = '0; obs_fe = 1'b0;
    endtask

    task automatic push_tick(input logic lvl, input logic [2:0] ev, input logic val, input logic bsy);
        tick_t t;
        t.lvl = lvl; t.ev = ev; t.val = val; t.busy = bsy;
        tq.push_back(t);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push_tick(1'b1, 3'd0, 1'b0, 1'b0);
    endtask

    // Line starts falling at r=0; bit k spans ticks [k*OS, k*OS+OS-1]; its decision tick is k*OS+1+DEC.
    task automatic add_frame(input logic [DW-1:0] data, input logic pbit, input logic sbit,
                             input logic [DW-1:0] glitch);
        logic lv [LEN];
        logic bits [DW+3];
        int   s_stop;
        int   k;
        logic [2:0] ev;
        logic val;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i+1] = data[i];
        bits[DW+1] = pbit;
        bits[DW+2] = sbit;
        for (int r = 0; r < LEN; r++) begin
            lv[r] = bits[r / OS];
            if ((r / OS == DW + 2) && !sbit) lv[r] = ((r % OS) <= 1 + DEC) ? 1'b0 : 1'b1;
        end
        for (int i = 0; i < DW; i++)
            if (glitch[i] && !data[i]) lv[OS * (i + 1) + DEC] = 1'b1;
        s_stop = OS * (DW + 2) + 1 + DEC;
        for (int r = 0; r < LEN; r++) begin
            ev = 3'd0; val = 1'b0;
            if (r >= 1 + DEC && ((r - 1 - DEC) % OS) == 0) begin
                k = (r - 1 - DEC) / OS;
                ev = (k == 0) ? 3'd1 : (k <= DW) ? 3'd2 : (k == DW + 1) ? 3'd3 : 3'd4;
                if (MAJ) val = (lv[r-2] & lv[r-1]) | (lv[r-2] & lv[r]) | (lv[r-1] & lv[r]);
                else     val = lv[r];
            end
            push_tick(lv[r], ev, val, (r >= 1 && r <= s_stop));
        end
    endtask

    // Low for 4 ticks, then high; receiver must give up at its decision tick.
    task automatic add_false();
        for (int r = 0; r <= 1 + DEC; r++) push_tick((r < 4) ? 1'b0 : 1'b1, 3'd0, 1'b0, (r >= 1));
    endtask

    task automatic check_quiet(input logic exp_busy);
        cmp("quiet_pulses", 32'({start_bit_detected, shift, parity_load, check_stop, frame_done}), 32'd0);
        cmp("quiet_busy", 32'(busy), 32'(exp_busy));
        cmp("quiet_parity_error", 32'(parity_error), 32'(pe_cur));
    endtask

    task automatic check_tick(input tick_t t);
        logic exp_fe;
        exp_fe = ~t.val | pe_cur;
        cmp("tick_outputs",
            32'({start_bit_detected, shift, parity_load, check_stop, frame_done, busy, parity_error}),
            32'({t.ev == 3'd1, t.ev == 3'd2, t.ev == 3'd3, t.ev == 3'd4, t.ev == 3'd4, t.busy, pe_cur}));
        if (t.ev >= 3'd2) cmp("tick_bit_value", 32'(bit_value), 32'(t.val));
        if (t.ev == 3'd4) cmp("tick_frame_error", 32'(frame_error), 32'(exp_fe));
        if (start_bit_detected) obs_start++;
        if (shift) begin
            if (obs_cnt < DW) obs_bits[obs_cnt] = bit_value;
            obs_cnt++;
        end
        if (frame_done) begin obs_fd++; obs_fe = frame_error; end
        case (t.ev)
            3'd1:    acc = 1'b0;
            3'd2:    acc = acc ^ t.val;
            3'd3:    pe_cur = acc ^ t.val;
            default: ;
        endcase
    endtask

    // Inputs change at negedge, outputs are checked 1 time unit later, posedge commits.
    task automatic apply_n(input int n);
        tick_t t;
        int gap;
        for (int i = 0; i < n && tq.size() > 0; i++) begin
            t   = tq.pop_front();
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                baud_tick = 1'b0; rx_in = t.lvl; #1;
                check_quiet(t.busy);
                @(posedge rx_clk); @(negedge rx_clk);
            end
            baud_tick = 1'b1; rx_in = t.lvl; #1;
            check_tick(t);
            @(posedge rx_clk); @(negedge rx_clk);
        end
        baud_tick = 1'b0;
    endtask

    task automatic apply_all();
        apply_n(tq.size());
    endtask

    task automatic do_reset_check(input string name);
        reset = 1'b1; baud_tick = 1'b1; rx_in = 1'b0;
        @(posedge rx_clk); @(negedge rx_clk);
        reset = 1'b0; baud_tick = 1'b0; rx_in = 1'b1; #1;
        pe_cur = 1'b0;
        cmp(name, 32'({start_bit_detected, shift, parity_load, check_stop, frame_done,
                       frame_error, parity_error, bit_value, busy}), 32'd0);
        @(posedge rx_clk); @(negedge rx_clk);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          pb, sb;
        vecs[0] = '{data: 8'h5A, pbit: 1'b0, sbit: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h01, pbit: 1'b0, sbit: 1'b1, exp_pe: 1'b1, exp_fe: 1'b1};
        vecs[2] = '{data: 8'h01, pbit: 1'b1, sbit: 1'b0, exp_pe: 1'b0, exp_fe: 1'b1};
        vecs[3] = '{data: 8'hFF, pbit: 1'b0, sbit: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vecs[4] = '{data: 8'h80, pbit: 1'b1, sbit: 1'b1, exp_pe: 1'b0, exp_fe: 1'b0};
        vecs[5] = '{data: 8'h00, pbit: 1'b1, sbit: 1'b1, exp_pe: 1'b1, exp_fe: 1'b1};

        reset = 1'b1; rx_en = 1'b1; rx_in = 1'b1; baud_tick = 1'b0;
        repeat (2) @(posedge rx_clk);
        @(negedge rx_clk);
        reset = 1'b0; #1;
        cmp("reset_state", 32'({start_bit_detected, shift, parity_load, check_stop, frame_done,
                                frame_error, parity_error, bit_value, busy}), 32'd0);
        @(posedge rx_clk); @(negedge rx_clk);
        add_idle(3); apply_all();

        for (int v = 0; v < 6; v++) begin
            clear_obs();
            add_frame(vecs[v].data, vecs[v].pbit, vecs[v].sbit, '0);
            add_idle(4);
            apply_all();
            cmp("vec_start_count", 32'(obs_start), 32'd1);
            cmp("vec_shift_count", 32'(obs_cnt), 32'(DW));
            cmp("vec_bits_lsb_first", 32'(obs_bits), 32'(vecs[v].data));
            cmp("vec_parity_error", 32'(parity_error), 32'(vecs[v].exp_pe));
            cmp("vec_frame_done_count", 32'(obs_fd), 32'd1);
            cmp("vec_frame_error", 32'(obs_fe), 32'(vecs[v].exp_fe));
        end

        // false start: 4 low ticks
        clear_obs();
        add_idle(2); add_false(); add_idle(5); apply_all();
        cmp("false_start_pulse", 32'(obs_start), 32'd0);
        cmp("false_start_idle", 32'(busy), 32'd0);

        // rx_en dropped in DATA after the third shift
        clear_obs();
        add_frame(8'hC3, 1'b0, 1'b1, '0);
        apply_n(OS * 3 + 1 + DEC + 3);
        tq.delete();
        cmp("rxen_pre_busy", 32'(busy), 32'd1);
        rx_en = 1'b0; baud_tick = 1'b0; #1;
        @(posedge rx_clk); @(negedge rx_clk);
        rx_en = 1'b1; rx_in = 1'b1; #1;
        cmp("rxen_drop_idle", 32'(busy), 32'd0);
        cmp("rxen_drop_parity_held", 32'(parity_error), 32'(pe_cur));
        cmp("rxen_drop_no_done", 32'(obs_fd), 32'd0);
        cmp("rxen_drop_shifts", 32'(obs_cnt), 32'd3);
        @(posedge rx_clk); @(negedge rx_clk);
        add_idle(4); apply_all();

        // reset mid-frame with parity_error set, then a clean 0xFF frame
        add_frame(8'h01, 1'b0, 1'b1, '0); add_idle(2); apply_all();
        cmp("pre_reset_parity_error", 32'(parity_error), 32'd1);
        add_frame(8'h3C, 1'b0, 1'b1, '0);
        apply_n(OS * 3 + 1 + DEC + 1);
        tq.delete();
        do_reset_check("midframe_reset_outputs");
        clear_obs();
        add_idle(2); add_frame(8'hFF, 1'b0, 1'b1, '0); add_idle(3); apply_all();
        cmp("post_reset_shift_count", 32'(obs_cnt), 32'd8);
        cmp("post_reset_frame_error", 32'(obs_fe), 32'd0);
        cmp("post_reset_frame_done", 32'(obs_fd), 32'd1);

`ifdef RX_MAJORITY_VOTE_EN
        clear_obs();
        add_frame(8'hA4, 1'b1, 1'b1, 8'hFF); add_idle(3); apply_all();
        cmp("glitch_bits", 32'(obs_bits), 32'h0A4);
        cmp("glitch_frame_error", 32'(obs_fe), 32'd0);
`endif

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                add_false();
            end else begin
                d  = DW'($urandom);
                pb = (^d) ^ ($urandom_range(0, 3) == 0);
                sb = ($urandom_range(0, 3) != 0);
                add_frame(d, pb, sb, MAJ ? DW'($urandom) : '0);
            end
            add_idle($urandom_range(1, 6));
            apply_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
